// File: rtl/riscv_mc_pkg.sv
// Shared types for the multicore RV32I memory subsystem.
// Pure declarations: no logic, no latency.
// No flow control of its own; consumers define their own handshakes.
package riscv_mc_pkg;

   localparam int NUM_CORES_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } arb_state_t;

   typedef logic [$clog2(NUM_CORES_DEF)-1:0] core_idx_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first set request at or after ptr, wrapping at N-1.
// Purely combinational, zero latency.
// No backpressure; valid is low when no request is set.
module rr_picker
   import riscv_mc_pkg::*;
#(
   parameter int N  = NUM_CORES_DEF,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          valid,
   output logic [IW-1:0] idx
);

   // one spare bit so ptr+i never overflows before the wrap subtraction
   logic [IW:0] cand;

   always_comb begin
      valid = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int i = 0; i < N; i++) begin
         cand = {1'b0, ptr} + (IW+1)'(i);
         if (cand >= (IW+1)'(N)) begin
            cand = cand - (IW+1)'(N);
         end
         if (!valid && req[cand[IW-1:0]]) begin
            valid = 1'b1;
            idx   = cand[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter serialising NUM_CORES load/store requests onto one memory port.
// Latency 2 cycles request-to-ack with zero wait states; one transfer per 3 cycles.
// Backpressure: mem_ready_i stalls BUSY; cores hold req_i until ack. Bus lock under MEM_ARB_LOCK_EN.
module mem_arbiter
   import riscv_mc_pkg::*;
#(
   parameter int NUM_CORES = NUM_CORES_DEF,
   parameter int AW        = 32,
   parameter int DW        = 32
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NUM_CORES-1:0]          req_i,
   input  logic [NUM_CORES-1:0]          we_i,
   input  logic [NUM_CORES-1:0][AW-1:0]  addr_i,
   input  logic [NUM_CORES-1:0][DW-1:0]  wdata_i,
   input  logic [NUM_CORES-1:0]          lock_i,
   output logic [NUM_CORES-1:0]          ack_o,
   output logic [DW-1:0]                 rdata_o,
   output logic                          mem_valid_o,
   output logic                          mem_we_o,
   output logic [AW-1:0]                 mem_addr_o,
   output logic [DW-1:0]                 mem_wdata_o,
   input  logic                          mem_ready_i,
   input  logic [DW-1:0]                 mem_rdata_i
);

   localparam int IW = $clog2(NUM_CORES);

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } xfer_t;

   arb_state_t           state;
   logic [IW-1:0]        rr_ptr;
   logic [IW-1:0]        win_idx;
   logic [IW-1:0]        ptr_next;
   xfer_t                xfer;
   logic [DW-1:0]        rdata_q;
   logic [NUM_CORES-1:0] pick_req;
   logic                 pick_vld;
   logic [IW-1:0]        pick_idx;
   logic                 rr_hold;

`ifdef MEM_ARB_LOCK_EN
   logic                 locked;
   logic [IW-1:0]        lock_owner;
   logic [NUM_CORES-1:0] owner_mask;
   logic                 lock_drop;
   logic                 lock_hold;

   assign owner_mask = NUM_CORES'(1) << lock_owner;
   // owner walked away from the bus without a locked request: release now
   assign lock_drop  = locked & ~req_i[lock_owner] & ~lock_i[lock_owner];
   assign lock_hold  = locked & ~lock_drop;
   assign pick_req   = lock_hold ? (req_i & owner_mask) : req_i;
   assign rr_hold    = locked;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         locked     <= 1'b0;
         lock_owner <= '0;
      end else if (state == IDLE && lock_drop) begin
         locked     <= 1'b0;
      end else if (state == RESP) begin
         if (lock_i[win_idx]) begin
            locked     <= 1'b1;
            lock_owner <= win_idx;
         end else if (locked) begin
            locked     <= 1'b0;
         end
      end
   end
`else
   logic unused_lock;

   assign unused_lock = ^lock_i;
   assign pick_req    = req_i;
   assign rr_hold     = 1'b0;
`endif

   rr_picker #(
      .N  (NUM_CORES),
      .IW (IW)
   ) u_rr_picker (
      .req   (pick_req),
      .ptr   (rr_ptr),
      .valid (pick_vld),
      .idx   (pick_idx)
   );

   assign ptr_next = (win_idx == IW'(NUM_CORES-1)) ? '0 : win_idx + IW'(1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         rr_ptr  <= '0;
         win_idx <= '0;
         xfer    <= '0;
         rdata_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_vld) begin
                  win_idx    <= pick_idx;
                  xfer.we    <= we_i[pick_idx];
                  xfer.addr  <= addr_i[pick_idx];
                  xfer.wdata <= wdata_i[pick_idx];
                  state      <= BUSY;
               end
            end
            BUSY: begin
               if (mem_ready_i) begin
                  if (!xfer.we) begin
                     rdata_q <= mem_rdata_i;
                  end
                  state <= RESP;
               end
            end
            RESP: begin
               if (!rr_hold) begin
                  rr_ptr <= ptr_next;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign mem_valid_o = (state == BUSY);
   assign mem_we_o    = (state == BUSY) & xfer.we;
   assign mem_addr_o  = xfer.addr;
   assign mem_wdata_o = xfer.wdata;
   assign ack_o       = (state == RESP) ? (NUM_CORES'(1) << win_idx) : '0;
   assign rdata_o     = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a scoreboard of expected transfers.
// Cores are modelled as op queues; the memory is a small array with programmable wait states.
`timescale 1ns/1ps
module tb_mem_arbiter;

   localparam int NC = 4;

   logic                   clk     = 1'b0;
   logic                   reset_n = 1'b1;
   logic [NC-1:0]          req_i   = '0;
   logic [NC-1:0]          we_i    = '0;
   logic [NC-1:0]          lock_i  = '0;
   logic [NC-1:0][31:0]    addr_i  = '0;
   logic [NC-1:0][31:0]    wdata_i = '0;
   logic [NC-1:0]          ack_o;
   logic [31:0]            rdata_o;
   logic                   mem_valid_o;
   logic                   mem_we_o;
   logic [31:0]            mem_addr_o;
   logic [31:0]            mem_wdata_o;
   logic                   mem_ready_i = 1'b1;
   logic [31:0]            mem_rdata_i;

   logic [31:0] mem [256];
   assign mem_rdata_i = mem[mem_addr_o[9:2]];

   always #5 clk = ~clk;

   mem_arbiter #(.NUM_CORES(NC), .AW(32), .DW(32)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req_i       (req_i),
      .we_i        (we_i),
      .addr_i      (addr_i),
      .wdata_i     (wdata_i),
      .lock_i      (lock_i),
      .ack_o       (ack_o),
      .rdata_o     (rdata_o),
      .mem_valid_o (mem_valid_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_ready_i (mem_ready_i),
      .mem_rdata_i (mem_rdata_i)
   );

   typedef struct {
      bit          we;
      bit          lock;
      logic [31:0] addr;
      logic [31:0] wdata;
   } op_t;

   typedef struct {
      int          core;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      int          lat;
      int          gap;
   } exp_t;

   op_t         ops [NC][$];
   exp_t        sb [$];
   int          checks    = 0;
   int          failures  = 0;
   int          cyc       = 0;
   int          last_ack  = 0;
   int          wait_left = 0;
   int          req_cyc [NC];
   logic [NC-1:0] pend    = '0;
   logic [31:0] exp_rdata = '0;

   function automatic logic [31:0] init_val(input logic [31:0] a);
      return 32'hA500_0000 ^ (a * 32'h0001_0003);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_op(input int c, input bit we, input logic [31:0] a,
                          input logic [31:0] wd, input bit lk);
      op_t o;
      o.we = we; o.lock = lk; o.addr = a; o.wdata = wd;
      ops[c].push_back(o);
   endtask

   task automatic expect_x(input int c, input bit we, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input int lat, input int gap);
      exp_t e;
      e.core = c; e.we = we; e.addr = a; e.wdata = wd; e.rdata = rd;
      e.lat = lat; e.gap = gap;
      sb.push_back(e);
   endtask

   function automatic bit work_left();
      bit w;
      w = (sb.size() != 0) || (pend != '0);
      for (int c = 0; c < NC; c++) if (ops[c].size() != 0) w = 1'b1;
      return w;
   endfunction

   // one clock: act on last cycle's ack, check outputs, drive memory and cores
   task automatic step();
      exp_t e;
      @(negedge clk);
      cyc++;
      for (int c = 0; c < NC; c++) begin
         if (pend[c]) begin
            if (ops[c].size() != 0) void'(ops[c].pop_front());
            req_i[c]  = 1'b0;
            lock_i[c] = 1'b0;
         end
      end
      pend = '0;

      if (mem_valid_o) begin
         if (sb.size() == 0) begin
            chk("unexpected_valid", 64'(mem_valid_o), 64'd0);
         end else begin
            chk("mem_addr", 64'(mem_addr_o), 64'(sb[0].addr));
            chk("mem_we", 64'(mem_we_o), 64'(sb[0].we));
            if (sb[0].we) chk("mem_wdata", 64'(mem_wdata_o), 64'(sb[0].wdata));
            chk("ack_in_busy", 64'(ack_o), 64'd0);
         end
      end

      if (ack_o != '0) begin
         pend = ack_o;
         if (sb.size() == 0) begin
            chk("unexpected_ack", 64'(ack_o), 64'd0);
         end else begin
            e = sb.pop_front();
            chk("ack_core", 64'(ack_o), 64'd1 << e.core);
            if (!e.we) exp_rdata = e.rdata;
            chk("rdata", 64'(rdata_o), 64'(exp_rdata));
            chk("valid_in_resp", 64'(mem_valid_o), 64'd0);
            if (e.lat >= 0) chk("latency", 64'(cyc - req_cyc[e.core]), 64'(e.lat));
            if (e.gap >= 0) chk("ack_gap", 64'(cyc - last_ack), 64'(e.gap));
         end
         last_ack = cyc;
      end

      if (mem_valid_o) begin
         if (wait_left > 0) begin
            mem_ready_i = 1'b0;
            wait_left--;
         end else begin
            mem_ready_i = 1'b1;
            if (mem_we_o) mem[mem_addr_o[9:2]] = mem_wdata_o;
         end
      end else begin
         mem_ready_i = 1'b1;
      end

      for (int c = 0; c < NC; c++) begin
         if (!req_i[c] && ops[c].size() != 0) begin
            req_i[c]   = 1'b1;
            we_i[c]    = ops[c][0].we;
            addr_i[c]  = ops[c][0].addr;
            wdata_i[c] = ops[c][0].wdata;
            lock_i[c]  = ops[c][0].lock;
            req_cyc[c] = cyc;
         end
      end
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      while (work_left() && n < budget) begin
         step();
         n++;
      end
      chk("drain_timeout", 64'(n >= budget), 64'd0);
      step();
      step();
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #1;
      chk("rst_valid_now", 64'(mem_valid_o), 64'd0);
      chk("rst_ack_now", 64'(ack_o), 64'd0);
      req_i = '0; we_i = '0; lock_i = '0; addr_i = '0; wdata_i = '0;
      sb.delete();
      for (int c = 0; c < NC; c++) ops[c].delete();
      pend = '0; wait_left = 0; mem_ready_i = 1'b1; exp_rdata = '0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_mem_we", 64'(mem_we_o), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr_o), 64'd0);
      chk("rst_mem_wdata", 64'(mem_wdata_o), 64'd0);
      chk("rst_rdata", 64'(rdata_o), 64'd0);
      reset_n  = 1'b1;
      last_ack = cyc;
      step();
      chk("idle_after_reset", 64'(mem_valid_o), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = init_val(32'(i) << 2);
      mem[8'h40] = 32'hDEAD_BEEF;
      @(negedge clk);
      do_reset();

      // single core read, zero wait states
      push_op(2, 1'b0, 32'h100, 32'h0, 1'b0);
      expect_x(2, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 2, -1);
      drain(40);

      // pointer now 3: core 3 ahead of core 0
      push_op(0, 1'b0, 32'h010, 32'h0, 1'b0);
      push_op(3, 1'b0, 32'h014, 32'h0, 1'b0);
      expect_x(3, 1'b0, 32'h014, 32'h0, init_val(32'h014), 2, -1);
      expect_x(0, 1'b0, 32'h010, 32'h0, init_val(32'h010), -1, 3);
      drain(40);

      // all cores continuously: strict rotation, one ack per 3 cycles
      do_reset();
      for (int r = 0; r < 2; r++) begin
         for (int c = 0; c < NC; c++) begin
            push_op(c, 1'b0, 32'h080 + 32'(r*16 + c*4), 32'h0, 1'b0);
         end
      end
      for (int r = 0; r < 2; r++) begin
         for (int c = 0; c < NC; c++) begin
            expect_x(c, 1'b0, 32'h080 + 32'(r*16 + c*4), 32'h0,
                     init_val(32'h080 + 32'(r*16 + c*4)),
                     (r == 0 && c == 0) ? 2 : -1, (r == 0 && c == 0) ? -1 : 3);
         end
      end
      drain(100);

      // write with four wait states; rdata_o keeps the earlier read value
      do_reset();
      push_op(1, 1'b0, 32'h024, 32'h0, 1'b0);
      expect_x(1, 1'b0, 32'h024, 32'h0, init_val(32'h024), 2, -1);
      drain(40);
      wait_left = 4;
      push_op(1, 1'b1, 32'h020, 32'h55, 1'b0);
      expect_x(1, 1'b1, 32'h020, 32'h55, 32'h0, 6, -1);
      drain(40);
      chk("mem_written", 64'(mem[8'h08]), 64'h55);

      // reset during BUSY abandons the transfer and restores rr_ptr
      do_reset();
      push_op(1, 1'b0, 32'h040, 32'h0, 1'b0);
      expect_x(1, 1'b0, 32'h040, 32'h0, init_val(32'h040), 2, -1);
      drain(40);
      wait_left = 3;
      push_op(3, 1'b0, 32'h048, 32'h0, 1'b0);
      expect_x(3, 1'b0, 32'h048, 32'h0, init_val(32'h048), -1, -1);
      for (int n = 0; n < 20 && !mem_valid_o; n++) step();
      chk("reached_busy", 64'(mem_valid_o), 64'd1);
      do_reset();
      push_op(2, 1'b0, 32'h050, 32'h0, 1'b0);
      push_op(0, 1'b0, 32'h054, 32'h0, 1'b0);
      expect_x(0, 1'b0, 32'h054, 32'h0, init_val(32'h054), 2, -1);
      expect_x(2, 1'b0, 32'h050, 32'h0, init_val(32'h050), -1, 3);
      drain(40);

`ifdef MEM_ARB_LOCK_EN
      // core 0 keeps the bus for three transfers while core 1 waits
      do_reset();
      push_op(0, 1'b0, 32'h030, 32'h0, 1'b1);
      push_op(0, 1'b0, 32'h034, 32'h0, 1'b1);
      push_op(0, 1'b0, 32'h038, 32'h0, 1'b0);
      push_op(1, 1'b0, 32'h03C, 32'h0, 1'b0);
      expect_x(0, 1'b0, 32'h030, 32'h0, init_val(32'h030), 2, -1);
      expect_x(0, 1'b0, 32'h034, 32'h0, init_val(32'h034), -1, 3);
      expect_x(0, 1'b0, 32'h038, 32'h0, init_val(32'h038), -1, 3);
      expect_x(1, 1'b0, 32'h03C, 32'h0, init_val(32'h03C), -1, 3);
      drain(60);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shared-memory arbiter for the four-core multicycle RV32I system. It serialises load/store requests from the `NUM_CORES` cores onto one single-ported memory/bus port using round-robin priority. It returns read data and a one-cycle acknowledge to the winning core. It sits between the core instances and the shared data memory in the multicore top level.

## Interface
- `NUM_CORES`, default 4: number of requesters; must be 2..8.
- `AW`, default 32: address width.
- `DW`, default 32: data width.
- `clk` in 1: single system clock; all state changes on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_i` in `NUM_CORES`: per-core request. Held high, with the core's fields stable, until its `ack_o` bit pulses.
- `we_i` in `NUM_CORES`: per-core write enable (1 = store).
- `addr_i` in `NUM_CORES`×`AW`: per-core address, packed array.
- `wdata_i` in `NUM_CORES`×`DW`: per-core store data.
- `lock_i` in `NUM_CORES`: per-core bus-lock request; used only with `MEM_ARB_LOCK_EN`.
- `ack_o` out `NUM_CORES`: one-hot, one-cycle completion pulse.
- `rdata_o` out `DW`: read data, shared by all cores. Valid in the `ack_o` cycle; holds its value otherwise.
- `mem_valid_o` out 1: memory request valid.
- `mem_we_o` out 1: memory write enable.
- `mem_addr_o` out `AW`: memory address.
- `mem_wdata_o` out `DW`: memory write data.
- `mem_ready_i` in 1: memory accepts and completes the transfer this cycle. Read data is valid on `mem_rdata_i` in the same cycle.
- `mem_rdata_i` in `DW`: memory read data.

## Operation
- FSM states are IDLE, BUSY and RESP. Reset state is IDLE.
- **IDLE**
  - If `req_i != 0`, the round-robin picker selects a winner: the first set bit at or after `rr_ptr`, wrapping from `NUM_CORES-1` to 0.
  - Latch the winner index, plus the winner's `we`, `addr` and `wdata`, into registers.
  - Go to BUSY.
- **BUSY**
  - `mem_valid_o`=1. `mem_*` outputs are driven only from the latched registers.
  - Wait any number of cycles for `mem_ready_i`.
  - On `mem_ready_i`=1: capture `mem_rdata_i` into `rdata_o` (reads only; writes leave `rdata_o` unchanged), then go to RESP.
- **RESP**
  - `ack_o[winner]`=1 for exactly this cycle.
  - `rr_ptr` ← (winner+1) mod `NUM_CORES`.
  - Go to IDLE.
- A core samples `ack_o` at the edge ending RESP and deasserts `req_i` by the next cycle. A `req_i` still high in the following IDLE cycle is a new request.
- Requests that arrive while BUSY or RESP are not lost: they stay pending until IDLE.
- `req_i` bits that drop before being granted are legal and are simply not granted. Dropping `req_i` after grant has no effect: the latched transfer completes and is acknowledged.
- Fairness: a continuously requesting core waits at most `NUM_CORES-1` transfers.
- `mem_valid_o`=1 only in BUSY. `ack_o` is nonzero only in RESP.
- **Reset values**
  - FSM in IDLE; `rr_ptr`=0.
  - `ack_o`=0, `mem_valid_o`=0, `mem_we_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0, `rdata_o`=0.
- **Reset mid-operation:** an in-flight transfer is abandoned and no ack is issued. The memory must tolerate `mem_valid_o` dropping without `mem_ready_i`.

## Timing
- Grant decision: combinational in IDLE, registered at the IDLE→BUSY edge.
- Best case, `mem_ready_i` high in the first BUSY cycle:
  - request in cycle 0 (IDLE), `mem_valid_o` in cycle 1, `ack_o` in cycle 2.
  - Latency is 2 cycles; throughput is one transfer per 3 cycles.
- Each extra cycle of `mem_ready_i` low adds one cycle.
- `rdata_o` is registered and stable from RESP until the next read completes.

## Configuration
- `MEM_ARB_LOCK_EN` defined:
  - In RESP, if `lock_i[winner]`=1, set `locked`=1 and `lock_owner`=winner.
  - While `locked`, IDLE grants only `lock_owner`. Other requests wait, and `rr_ptr` is not advanced.
  - `locked` clears in RESP of a locked-owner transfer whose `lock_i` is 0. It also clears in IDLE if `req_i[lock_owner]` and `lock_i[lock_owner]` are both 0.
  - `locked` resets to 0.
- `MEM_ARB_LOCK_EN` undefined: `lock_i` is present but ignored, and no lock state exists.

## Structure
- Shared package `riscv_mc_pkg` holds:
  - `NUM_CORES_DEF`;
  - the `arb_state_t` enum (IDLE/BUSY/RESP);
  - `core_idx_t` (`$clog2(NUM_CORES)` bits).
- Sub-module `rr_picker` is purely combinational. It takes `req` and `ptr` and returns `valid` and `idx`. It is reused by the future I/O arbiter.

## Test plan
1. **Single core:** after reset, core 2 reads 0x100, memory returns 0xDEADBEEF with `mem_ready_i` tied 1. Expect `mem_valid_o` in cycle 1, `mem_addr_o`=0x100, `ack_o`=4'b0100 in cycle 2, `rdata_o`=0xDEADBEEF.
2. **All four at once:** all cores request continuously from reset. Expect grants in order 0,1,2,3,0 and exactly one ack every 3 cycles.
3. **Wait states:** core 1 writes 0x55 to 0x20 with `mem_ready_i` low for 4 BUSY cycles. Expect `mem_*` stable throughout, ack 6 cycles after the request, `rdata_o` unchanged.
4. **Pointer wrap:** `rr_ptr`=3 after a core-2 grant; cores 0 and 3 then request. Expect core 3 first, then core 0.
5. **Reset mid-operation:** assert `reset_n` low during BUSY. Expect `mem_valid_o`=0 and `ack_o`=0 immediately, and IDLE after release.
6. **Lock (`MEM_ARB_LOCK_EN`):** core 0 holds `lock_i` for 3 transfers while core 1 also requests. Expect three core-0 acks, then core 1.
